// File: rtl/ublock_ti_pkg.sv
// Shared constants and types for the two-share uBlock-128 S-box layer.
package ublock_ti_pkg;

  // Nibbles in a 128-bit state.
  localparam int NIBBLES = 32;

  // Fibonacci feedback taps for x^16+x^14+x^13+x^11+1 with a right shift:
  // the new MSB is q[0]^q[2]^q[3]^q[5].
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Guard LFSR reset value and substitute for an all-zero seed.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Sequencer state encoding.
  typedef logic [1:0] seq_state_t;
  localparam seq_state_t ST_IDLE  = 2'd0;
  localparam seq_state_t ST_FEED  = 2'd1;
  localparam seq_state_t ST_DRAIN = 2'd2;
  localparam seq_state_t ST_DONE  = 2'd3;

  // uBlock 4-bit S-box; entry i sits at bits [4i+3:4i].
  localparam logic [63:0] UBLOCK_SBOX = 64'h5230_61EF_8DAB_C947;

  // One step of the guard LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {^(q & LFSR_TAPS), q[15:1]};
  endfunction

endpackage

// File: rtl/guard_lfsr.sv
// 16-bit Fibonacci LFSR supplying guard randomness to the shared S-box.
// A zero seed is replaced by SEED so the register can never lock at zero.
module guard_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  import ublock_ti_pkg::*;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next value: seed load has priority, otherwise advance when enabled.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      if (seed == 16'h0000) begin
        lfsr_d = SEED;
      end else begin
        lfsr_d = seed;
      end
    end else if (en) begin
      lfsr_d = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register, reset to SEED.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/sbox_layer_seq.sv
// Serial driver/collector for the two-share threshold S-box layer of
// uBlock-128. Streams one nibble pair per cycle to an external shared
// S-box and reassembles its output shares. Shares are never combined here.
module sbox_layer_seq #(
  parameter int          NIBBLES   = 32,
  parameter int          SBOX_LAT  = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   state0_in,
  input  logic [4*NIBBLES-1:0]   state1_in,
  input  logic                   seed_valid,
  input  logic [15:0]            seed,
  output logic [3:0]             sb_in0,
  output logic [3:0]             sb_in1,
  output logic [1:0]             guards,
  input  logic [3:0]             sb_out0,
  input  logic [3:0]             sb_out1,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   state0_out,
  output logic [4*NIBBLES-1:0]   state1_out
);
  import ublock_ti_pkg::*;

  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = $clog2(NIBBLES + 1);

  seq_state_t          state_q, state_d;
  logic [W-1:0]        sh0_q, sh0_d;
  logic [W-1:0]        sh1_q, sh1_d;
  logic [W-1:0]        res0_q, res0_d;
  logic [W-1:0]        res1_q, res1_d;
  logic [CNT_W-1:0]    iss_cnt_q, iss_cnt_d;
  logic [CNT_W-1:0]    cap_cnt_q, cap_cnt_d;
  logic [SBOX_LAT-1:0] vld_q, vld_d;

  logic        idle_s;
  logic        feed_s;
  logic        cap_s;
  logic [15:0] lfsr_s;
  logic [13:0] lfsr_unused_s;

  assign idle_s = (state_q == ST_IDLE);
  assign feed_s = (state_q == ST_FEED);
  // A nibble pair returns exactly SBOX_LAT cycles after it was issued.
  assign cap_s  = vld_q[SBOX_LAT-1];

  // Upper LFSR bits only feed the recurrence, never the S-box.
  assign lfsr_unused_s = lfsr_s[15:2];

  guard_lfsr #(
    .SEED (LFSR_SEED)
  ) u_guard_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .en   (feed_s),
    .load (idle_s & seed_valid),
    .seed (seed),
    .q    (lfsr_s)
  );

  // Sequencer: state transitions, input shift registers and issue counter.
  always_comb begin
    state_d   = state_q;
    sh0_d     = sh0_q;
    sh1_d     = sh1_q;
    iss_cnt_d = iss_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FEED;
          sh0_d     = state0_in;
          sh1_d     = state1_in;
          iss_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FEED: begin
        sh0_d     = {4'b0000, sh0_q[W-1:4]};
        sh1_d     = {4'b0000, sh1_q[W-1:4]};
        iss_cnt_d = iss_cnt_q + CNT_W'(1);
        if (iss_cnt_q == CNT_W'(NIBBLES - 1)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FEED;
        end
      end
      ST_DRAIN: begin
        // Leave on the edge of the last capture so done lines up with it.
        if (cap_cnt_d == CNT_W'(NIBBLES)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Valid delay line tracking issued nibbles through the S-box pipeline.
  always_comb begin
    vld_d    = {SBOX_LAT{1'b0}};
    vld_d[0] = feed_s;
    for (int i = 1; i < SBOX_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  // Capture path: shift S-box outputs in from the top and count them.
  always_comb begin
    res0_d    = res0_q;
    res1_d    = res1_q;
    cap_cnt_d = cap_cnt_q;
    if (idle_s && start) begin
      cap_cnt_d = {CNT_W{1'b0}};
    end else if (cap_s) begin
      res0_d    = {sb_out0, res0_q[W-1:4]};
      res1_d    = {sb_out1, res1_q[W-1:4]};
      cap_cnt_d = cap_cnt_q + CNT_W'(1);
    end else begin
      cap_cnt_d = cap_cnt_q;
    end
  end

  // State, datapath and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      sh0_q     <= {W{1'b0}};
      sh1_q     <= {W{1'b0}};
      res0_q    <= {W{1'b0}};
      res1_q    <= {W{1'b0}};
      iss_cnt_q <= {CNT_W{1'b0}};
      cap_cnt_q <= {CNT_W{1'b0}};
      vld_q     <= {SBOX_LAT{1'b0}};
    end else begin
      state_q   <= state_d;
      sh0_q     <= sh0_d;
      sh1_q     <= sh1_d;
      res0_q    <= res0_d;
      res1_q    <= res1_d;
      iss_cnt_q <= iss_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      vld_q     <= vld_d;
    end
  end

  // S-box inputs and guards are forced to zero outside FEED.
  assign sb_in0     = feed_s ? sh0_q[3:0] : 4'b0000;
  assign sb_in1     = feed_s ? sh1_q[3:0] : 4'b0000;
  assign guards     = feed_s ? lfsr_s[1:0] : 2'b00;
  assign busy       = feed_s || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign state0_out = res0_q;
  assign state1_out = res1_q;

endmodule

// File: doc/sbox_layer_seq.md
# sbox_layer_seq

Serial driver and collector for the two-share threshold S-box layer of uBlock-128. It takes a two-share 128-bit state, streams one nibble pair per cycle into `fshared_sbox`, and supplies the S-box's guard randomness from an internal LFSR. It collects the S-box output shares back into a two-share 128-bit state and pulses `done`. The block sits between the round-state register and the shared S-box. The two shares are never combined inside it.

## Interface
Parameters:
- `NIBBLES`, 32: nibbles per state (128/4).
- `SBOX_LAT`, 2: register stages of the attached shared S-box, input to output; legal range 1..4.
- `LFSR_SEED`, 16'hACE1: guard LFSR value after reset and the substitute for a zero seed.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a layer pass; sampled only in IDLE.
- `state0_in`, input, 128: share 0 of input state; nibble k = bits [4k+3:4k].
- `state1_in`, input, 128: share 1 of input state.
- `seed_valid`, input, 1: load `seed` into the LFSR; honoured only in IDLE.
- `seed`, input, 16: fresh LFSR seed.
- `sb_in0`, output, 4: to S-box `d0c0b0a0`.
- `sb_in1`, output, 4: to S-box `d1c1b1a1`.
- `guards`, output, 2: to S-box `guards`.
- `sb_out0`, input, 4: from S-box `h0g0f0e0`.
- `sb_out1`, input, 4: from S-box `h1g1f1e1`.
- `busy`, output, 1: high in FEED and DRAIN.
- `done`, output, 1: one-cycle pulse when results are valid.
- `state0_out`, output, 128: share 0 of the result.
- `state1_out`, output, 128: share 1 of the result.

## Operation
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE to FEED on `start`: load both shares into separate 128-bit shift registers; clear the issue counter and the capture counter.
- FEED: each cycle, drive nibble 0 of both shift registers onto `sb_in0`/`sb_in1`, shift right by 4, and increment the issue counter. After nibble NIBBLES-1 is issued, go to DRAIN.
- DRAIN: wait until the capture counter reaches NIBBLES, then go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE.
- Capture: an output nibble pair is valid SBOX_LAT cycles after its issue cycle. It is shifted into result registers from the top, so after NIBBLES captures nibble k sits at bits [4k+3:4k].
- Capture is driven by a SBOX_LAT-deep valid delay line, not by the FSM state. FEED and capture therefore overlap, and there are no bubbles.
- `state0_out`/`state1_out` are the result registers. They are valid from `done` and hold until the next `start`'s first capture.
- Guards: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1. It advances every FEED cycle and holds otherwise; `guards` = lfsr[1:0].
- A `seed` of 0 loads LFSR_SEED instead, so the LFSR never locks at zero.
- Outside FEED, `sb_in0`, `sb_in1` and `guards` are driven 0. No share value is presented idle.
- `start` outside IDLE is ignored. `seed_valid` and `start` together in IDLE: the seed loads and the pass starts, and the first guard uses the new seed.
- `rstn` low at any time: FSM goes to IDLE; all shift, result and delay-line registers clear to 0; the LFSR returns to LFSR_SEED; `busy`=0, `done`=0. No partial result or `done` is produced after reset.

## Timing
- Reset values: `busy` 0, `done` 0, `sb_in0`/`sb_in1` 0, `guards` 0, `state0_out`/`state1_out` 0.
- Let T be the edge that samples `start`. Nibble k is on `sb_in*` in cycle T+1+k. Its output is captured at edge T+1+k+SBOX_LAT.
- `done` is high in cycle T+NIBBLES+SBOX_LAT+1, which is 35 cycles after `start` with the defaults.
- `busy` rises the cycle after T and falls when `done` rises.
- Back-to-back: `start` may be accepted in the cycle `done` falls, which is the first IDLE cycle.

## Structure
- A shared package `ublock_ti_pkg` holds:
  - NIBBLES, the LFSR polynomial taps, and LFSR_SEED;
  - the FSM state typedef;
  - the uBlock S-box constant table, used by the bench only.
- One sub-module, `guard_lfsr`, with ports clk, rstn, en, load, seed and q[15:0].
- The top level instantiates `guard_lfsr`. It does not instantiate `fshared_sbox`; the bench wires that in.

## Test plan
- Unmasked pass:
  - Stimulus: `state1_in`=0, `state0_in`=128'h0123456789ABCDEF_FEDCBA9876543210, `start` pulse.
  - Required: `done` arrives 35 cycles later.
  - Required: `state0_out`^`state1_out` equals the per-nibble uBlock S-box of the input; nibble 0 (input 0) gives 7 and nibble 15 (input F) gives 5.
- Masked pass: random `state0_in`, with `state1_in` = random mask. The XOR of the outputs must equal S applied to (state0_in^state1_in). Repeat 1000 times with random seeds.
- Share separation: with `state1_in`=0, check that `sb_in1` is 0 in every cycle and that `sb_in0` carries only state0 nibbles in order 0..31.
- Ignored start and back-to-back:
  - Stimulus: pulse `start` again at T+10.
  - Required: no effect on that pass.
  - Stimulus: `start` in the first IDLE cycle after `done`.
  - Required: second `done` exactly 35 cycles after it.
- Reset mid-pass: drop `rstn` at T+20. Required:
  - all outputs 0 and FSM in IDLE;
  - no `done` afterwards;
  - a following pass correct, with `guards` restarting from LFSR_SEED.
- Seed handling:
  - `seed_valid` with `seed`=0: the LFSR holds LFSR_SEED.
  - `seed_valid` with `seed`=16'h0001: the first FEED cycle has `guards`=2'b01.
  - `guards`=0 outside FEED.
